// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the datapath and a word-organised data memory.
// Optional macro LSU_MISALIGN_FAULT_EN: fault misaligned halfword/word accesses instead of aligning them.
module load_store_unit #(
  parameter int MEM_WORDS = 128,
  parameter int IDX_W     = 7
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        IsStore,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic        Busy,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] LoadData,
  output logic [31:0] MemAddr,
  output logic        MemWE,
  output logic [31:0] MemWD,
  input  logic [31:0] MemRD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t      state, state_next;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        sign_ext_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] merge_q;
  logic [31:0] load_data_q;

  logic        illegal;
  logic        sub_word_store;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_value;
  logic [31:0] merged;

  // Request legality is judged on the live inputs so a bad request faults one cycle after Start.
  always_comb begin
    illegal = (Size == 2'b11)
            | (|Addr[31:IDX_W+2])
            | ({1'b0, Addr[IDX_W+1:2]} >= (IDX_W+1)'(MEM_WORDS));
`ifdef LSU_MISALIGN_FAULT_EN
    if (Size == 2'b01 && Addr[0])
      illegal = 1'b1;
    if (Size == 2'b10 && (|Addr[1:0]))
      illegal = 1'b1;
`endif
  end

  // Lane selection ignores the low bits that do not belong to the access size, which
  // also realigns misaligned requests when they are not faulted.
  always_comb begin
    byte_lane  = MemRD[{addr_q[1:0], 3'b000} +: 8];
    half_lane  = MemRD[{addr_q[1], 4'b0000} +: 16];
    load_value = MemRD;
    case (size_q)
      2'b00:   load_value = {{24{sign_ext_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_value = {{16{sign_ext_q & half_lane[15]}}, half_lane};
      default: load_value = MemRD;
    endcase
  end

  always_comb begin
    merged = merge_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wd_q[15:0];
      default: merged = merge_q;
    endcase
  end

  assign sub_word_store = is_store_q & (size_q != 2'b10);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= S_IDLE;
      is_store_q  <= 1'b0;
      size_q      <= '0;
      sign_ext_q  <= 1'b0;
      addr_q      <= '0;
      wd_q        <= '0;
      merge_q     <= '0;
      load_data_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (Start) begin
            is_store_q <= IsStore;
            size_q     <= Size;
            sign_ext_q <= SignExt;
            addr_q     <= Addr;
            wd_q       <= WD;
          end
        end
        S_ACCESS: begin
          if (!is_store_q)
            load_data_q <= load_value;
          else if (sub_word_store)
            merge_q <= MemRD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    Busy       = (state != S_IDLE);
    Done       = 1'b0;
    Fault      = 1'b0;
    MemWE      = 1'b0;
    MemWD      = '0;
    case (state)
      S_IDLE: begin
        if (Start)
          state_next = illegal ? S_FAULT : S_ACCESS;
      end
      S_ACCESS: begin
        if (sub_word_store) begin
          state_next = S_WRITE;
        end else begin
          state_next = S_DONE;
          if (is_store_q) begin
            MemWE = ~Reset;
            MemWD = wd_q;
          end
        end
      end
      S_WRITE: begin
        MemWE      = ~Reset;
        MemWD      = merged;
        state_next = S_DONE;
      end
      S_DONE: begin
        Done       = 1'b1;
        state_next = S_IDLE;
      end
      S_FAULT: begin
        Done       = 1'b1;
        Fault      = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign LoadData = load_data_q;
  assign MemAddr  = {2'b00, addr_q[31:2]};

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset/handshake
// sequences, then random requests against a byte-lane memory model.
module tb_load_store_unit;

  localparam int MEM_WORDS = 128;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        IsStore;
  logic [1:0]  Size;
  logic        SignExt;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [31:0] LoadData;
  logic [31:0] MemAddr;
  logic        MemWE;
  logic [31:0] MemWD;
  logic [31:0] MemRD;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] exp_load_data;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .IDX_W(7)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .IsStore(IsStore), .Size(Size),
    .SignExt(SignExt), .Addr(Addr), .WD(WD), .Busy(Busy), .Done(Done),
    .Fault(Fault), .LoadData(LoadData), .MemAddr(MemAddr), .MemWE(MemWE),
    .MemWD(MemWD), .MemRD(MemRD)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    MemRD = '0;
    if (MemAddr < 32'(MEM_WORDS))
      MemRD = mem[MemAddr[6:0]];
  end

  always @(posedge CLK)
    if (MemWE && MemAddr < 32'(MEM_WORDS))
      mem[MemAddr[6:0]] <= MemWD;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one request and observe it until Done (bounded); returns in the following IDLE cycle.
  task automatic run_op(input bit st, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic f, output int lat, output int nwe,
                        output logic [31:0] wa, output logic [31:0] wdat,
                        output logic [31:0] ld);
    @(negedge CLK);
    Start = 1'b1; IsStore = st; Size = sz; SignExt = sx; Addr = a; WD = wd;
    @(posedge CLK); #1;
    Start = 1'b0;
    lat = 1; nwe = 0; wa = '0; wdat = '0;
    while (!Done && lat < 8) begin
      if (MemWE) begin nwe++; wa = MemAddr; wdat = MemWD; end
      @(posedge CLK); #1;
      lat++;
    end
    if (MemWE) nwe++;
    if (!Done) lat = 99;
    f  = Fault;
    ld = LoadData;
    @(posedge CLK);
  endtask

  // Reference: plain byte-lane arithmetic on a word array.
  task automatic model(input bit st, input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       output bit f, output int lat, output int nwe);
    longint unsigned idx, sh, nb, mask, v, w;
    idx = 64'(a) >> 2;
    f = (sz == 2'd3) || (idx >= MEM_WORDS);
`ifdef LSU_MISALIGN_FAULT_EN
    if (sz == 2'd1 && a[0]) f = 1'b1;
    if (sz == 2'd2 && a[1:0] != 2'd0) f = 1'b1;
`endif
    nwe = 0;
    if (f) begin lat = 1; return; end
    nb = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    sh = (sz == 2'd0) ? 64'(a % 4) * 8 : (sz == 2'd1) ? 64'((a / 2) % 2) * 16 : 0;
    mask = (64'd1 << nb) - 1;
    w = 64'(ref_mem[idx]);
    if (!st) begin
      v = (w >> sh) & mask;
      if (sx && ((v >> (nb - 1)) & 1) == 1) v = v | (~mask);
      exp_load_data = v[31:0];
      lat = 2;
    end else begin
      w = (w & ~(mask << sh)) | ((64'(wd) & mask) << sh);
      ref_mem[idx] = w[31:0];
      lat = (nb == 32) ? 2 : 3;
      nwe = 1;
    end
  endtask

  typedef struct {
    bit          st;
    logic [1:0]  sz;
    bit          sx;
    logic [31:0] a;
    logic [31:0] wd;
    bit          exp_fault;
    int          exp_lat;
    logic [31:0] exp_data;
    logic [31:0] exp_wdat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic        f, mf;
    int          lat, nwe, mlat, mnwe, dcount;
    logic [31:0] wa, wdat, ld, ra, rw, idx;
    bit          rst_l;
    logic [1:0]  rsz;

    Reset = 1'b1; Start = 1'b0; IsStore = 1'b0; Size = '0; SignExt = 1'b0;
    Addr = '0; WD = '0;
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      mem[i] = $urandom;
    end
    mem[0] = 32'h89AB_CDEF; mem[1] = 32'h0000_000F; mem[2] = 32'h0000_00F0;
    mem[5] = 32'h0F0F_0F0F; mem[6] = 32'hF0F0_F0F0;
    for (int unsigned i = 0; i < MEM_WORDS; i++) ref_mem[i] = mem[i];
    exp_load_data = '0;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", 32'(Busy), 0);
    check("reset_done", 32'(Done), 0);
    check("reset_fault", 32'(Fault), 0);
    check("reset_memwe", 32'(MemWE), 0);
    check("reset_loaddata", LoadData, 0);
    check("reset_memaddr", MemAddr, 0);
    check("reset_memwd", MemWD, 0);
    @(negedge CLK);
    Reset = 1'b0;

    //           st  sz    sx  addr          wd            fault lat data          wdat
    vecs[0]  = '{0, 2'd0, 1, 32'h18,      32'h0,        0, 2, 32'hFFFF_FFF0, 32'h0};
    vecs[1]  = '{0, 2'd1, 0, 32'h16,      32'h0,        0, 2, 32'h0000_0F0F, 32'h0};
    vecs[2]  = '{1, 2'd0, 0, 32'h05,      32'h1234_56AB, 0, 3, 32'h0000_0F0F, 32'h0000_AB0F};
    vecs[3]  = '{1, 2'd2, 0, 32'h200,     32'hDEAD_BEEF, 1, 1, 32'h0000_0F0F, 32'h0};
`ifdef LSU_MISALIGN_FAULT_EN
    vecs[4]  = '{0, 2'd1, 0, 32'h03,      32'h0,        1, 1, 32'h0000_0F0F, 32'h0};
`else
    vecs[4]  = '{0, 2'd1, 0, 32'h03,      32'h0,        0, 2, 32'h0000_89AB, 32'h0};
`endif
    vecs[5]  = '{0, 2'd2, 0, 32'h04,      32'h0,        0, 2, 32'h0000_AB0F, 32'h0};
    vecs[6]  = '{0, 2'd0, 1, 32'h03,      32'h0,        0, 2, 32'hFFFF_FF89, 32'h0};
    vecs[7]  = '{0, 2'd3, 0, 32'h00,      32'h0,        1, 1, 32'hFFFF_FF89, 32'h0};
    vecs[8]  = '{1, 2'd1, 0, 32'h16,      32'h0000_CAFE, 0, 3, 32'hFFFF_FF89, 32'hCAFE_0F0F};
    vecs[9]  = '{0, 2'd1, 1, 32'h16,      32'h0,        0, 2, 32'hFFFF_CAFE, 32'h0};
    vecs[10] = '{1, 2'd2, 0, 32'h10,      32'h1122_3344, 0, 2, 32'hFFFF_CAFE, 32'h1122_3344};
    vecs[11] = '{0, 2'd0, 0, 32'h11,      32'h0,        0, 2, 32'h0000_0033, 32'h0};

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].st, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].wd, f, lat, nwe, wa, wdat, ld);
      model(vecs[i].st, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].wd, mf, mlat, mnwe);
      check($sformatf("vec%0d_fault", i), 32'(f), 32'(vecs[i].exp_fault));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_loaddata", i), ld, vecs[i].exp_data);
      check($sformatf("vec%0d_we_count", i), 32'(nwe),
            (vecs[i].st && !vecs[i].exp_fault) ? 32'd1 : 32'd0);
      if (vecs[i].st && !vecs[i].exp_fault) begin
        check($sformatf("vec%0d_we_addr", i), wa, vecs[i].a >> 2);
        check($sformatf("vec%0d_we_data", i), wdat, vecs[i].exp_wdat);
        check($sformatf("vec%0d_mem", i), mem[vecs[i].a[8:2]], vecs[i].exp_wdat);
      end
    end

    // Reset during WRITE of a byte store: no write, back to IDLE.
    @(negedge CLK);
    Start = 1'b1; IsStore = 1'b1; Size = 2'd0; SignExt = 1'b0; Addr = 32'h08; WD = 32'h0000_0055;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    #1;
    check("rst_write_memwe", 32'(MemWE), 0);
    @(posedge CLK); #1;
    Reset = 1'b0;
    check("rst_write_busy", 32'(Busy), 0);
    check("rst_write_done", 32'(Done), 0);
    check("rst_write_mem2", mem[2], 32'h0000_00F0);
    check("rst_write_loaddata", LoadData, 0);
    exp_load_data = '0;

    // Start held high across a whole load: exactly one Done.
    @(negedge CLK);
    Start = 1'b1; IsStore = 1'b0; Size = 2'd2; SignExt = 1'b0; Addr = 32'h18; WD = '0;
    @(posedge CLK); #1;
    dcount = 0; lat = 1;
    while (!Done && lat < 8) begin @(posedge CLK); #1; lat++; end
    if (Done) dcount++;
    Start = 1'b0;
    check("held_start_latency", 32'(lat), 2);
    check("held_start_data", LoadData, 32'hF0F0_F0F0);
    exp_load_data = 32'hF0F0_F0F0;
    repeat (5) begin @(posedge CLK); #1; if (Done) dcount++; end
    check("held_start_done_count", 32'(dcount), 1);
    check("held_start_idle", 32'(Busy), 0);

    // Random requests against the reference model.
    for (int n = 0; n < 300; n++) begin
      rst_l = 1'($urandom_range(0, 1));
      rsz   = 2'($urandom_range(0, 3));
      ra    = ($urandom_range(0, 135) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ra = $urandom;
      rw    = $urandom;
      idx   = ra >> 2;
      run_op(rst_l, rsz, 1'($urandom_range(0, 1)), ra, rw, f, lat, nwe, wa, wdat, ld);
      model(rst_l, rsz, SignExt, ra, rw, mf, mlat, mnwe);
      check($sformatf("rnd%0d_fault", n), 32'(f), 32'(mf));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(mlat));
      check($sformatf("rnd%0d_we_count", n), 32'(nwe), 32'(mnwe));
      check($sformatf("rnd%0d_loaddata", n), ld, exp_load_data);
      if (mnwe != 0) begin
        check($sformatf("rnd%0d_we_addr", n), wa, idx);
        check($sformatf("rnd%0d_we_data", n), wdat, ref_mem[idx[6:0]]);
        check($sformatf("rnd%0d_mem", n), mem[idx[6:0]], ref_mem[idx[6:0]]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle load/store unit placed between the datapath (ALU address, register write data) and the word-organised data memory. The data memory provides a word index port, a whole-word write enable and a combinational read.
- Converts byte addresses to word indices.
- Performs byte and halfword loads with optional sign extension.
- Implements sub-word stores as read-modify-write.
- Uses a Start/Busy/Done handshake so the control unit can stall.

Parameters:
MEM_WORDS, 128, number of 32-bit words in data memory; word index >= MEM_WORDS faults
IDX_W, 7, width of the in-range word index check (log2 MEM_WORDS)

Ports:
CLK  in  1  clock, all state updates on posedge
Reset  in  1  synchronous active-high reset
Start  in  1  request strobe; sampled only in IDLE
IsStore  in  1  1 = store, 0 = load
Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (faults)
SignExt  in  1  loads only: sign-extend sub-word result
Addr  in  32  byte address
WD  in  32  store data; byte/halfword taken from low bits
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle completion pulse
Fault  out  1  valid with Done: misaligned, out-of-range or reserved Size
LoadData  out  32  load result, held until next accepted Start
MemAddr  out  32  word index to data memory = {2'b00, latched Addr[31:2]}
MemWE  out  1  memory write enable
MemWD  out  32  memory write data
MemRD  in  32  memory read data (combinational from MemAddr)

Behaviour:
- Reset values: state IDLE; Busy, Done, Fault, MemWE = 0; LoadData, MemWD, latched request = 0.
- MemWE is gated with ~Reset, so a reset asserted mid-operation never writes. The FSM is in IDLE after the reset edge.
- IDLE:
  - On Start, latch IsStore, Size, SignExt, Addr and WD.
  - Go to FAULT if the request is illegal; otherwise go to ACCESS.
  - Start while Busy is ignored.
- Illegal request conditions:
  - Size == 11.
  - Word index >= MEM_WORDS.
  - Misaligned access (see Optional Feature).
- ACCESS (MemAddr driven):
  - Load: select lane Addr[1:0] (byte) or Addr[1] (halfword), little-endian. Zero- or sign-extend per SignExt and register into LoadData. Go to DONE.
  - Word store: MemWE = 1, MemWD = WD. Go to DONE.
  - Sub-word store: capture MemRD into a merge register. Go to WRITE.
- WRITE:
  - MemWE = 1.
  - MemWD = merge word with the addressed byte/halfword replaced by WD[7:0] / WD[15:0].
  - Go to DONE.
- DONE: Done = 1, Fault = 0. Go to IDLE.
- FAULT:
  - Done = 1, Fault = 1. Go to IDLE.
  - No MemWE; LoadData unchanged.
- Latency (Start sampled at edge N):
  - Load and word store: Done high in cycle N+2.
  - Sub-word store: Done high in cycle N+3.
  - Fault: Done high in cycle N+1.
- Back-to-back: Start may be asserted in the DONE cycle but is not accepted. It is accepted in the following IDLE cycle.
- MemWE is high for exactly one cycle per legal store and never for loads.

Optional Feature:
Macro LSU_MISALIGN_FAULT_EN.
- Defined: halfword with Addr[0] = 1 or word with Addr[1:0] != 00 goes to FAULT; no memory access.
- Undefined: low address bits are forced aligned (halfword Addr[0] = 0, word Addr[1:0] = 00) and the access proceeds normally; Fault is raised only for out-of-range or reserved Size.

Test Plan:
- Memory word 6 = 0xF0F0F0F0; load byte SignExt=1 Addr=0x18 -> Done at N+2, LoadData = 0xFFFFFFF0, Fault 0.
- Memory word 5 = 0x0F0F0F0F; load halfword SignExt=0 Addr=0x16 -> LoadData = 0x00000F0F.
- Memory word 1 = 0x0000000F; store byte WD=0x123456AB Addr=0x05 -> one MemWE pulse at N+2 with MemAddr=1, MemWD=0x0000AB0F; Done at N+3; memory word 1 reads 0x0000AB0F afterwards.
- Store word WD=0xDEADBEEF Addr=0x200 (index 128) -> Fault=1 with Done at N+1, MemWE never high. Halfword load Addr=0x03:
  - Macro defined: Fault=1.
  - Macro undefined: returns halfword at 0x02.
- Reset asserted during WRITE of a byte store to Addr=0x08 -> MemWE stays 0, memory word 2 unchanged (0x000000F0); Busy=0 after the edge. Start held high during Busy is ignored: only one Done per accepted request.
